// File: rtl/bus_arbiter_rr_pkg.sv
// ============================================================================
// Module      : bus_arbiter_rr_pkg
// Description : Shared limits, types and helpers for the round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arbiter_rr_pkg;

    localparam int c_max_masters  = 16;
    localparam int c_hold_w       = 8;
    localparam int c_def_max_hold = 16;

    typedef logic [c_hold_w-1:0] hold_cnt_t;

    // Index of the master after idx, wrapping at n.
    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arb_rr_pick.sv
// ============================================================================
// Module      : bus_arb_rr_pick
// Description : Combinational rotating-priority finder: first set request
//               bit at or after start, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arb_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin : p_pick
        int k;
        k     = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(start) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[k[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = k[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
// ============================================================================
// Module      : bus_arbiter_rr
// Description : Round-robin bus arbiter with parking, optional bus lock and
//               hold-time preemption (enabled by BUS_ARB_HOLD_LIMIT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int OWNER_W   = $clog2(N_MASTERS),
    parameter int MAX_HOLD  = c_def_max_hold
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] req_,
    input  logic [N_MASTERS-1:0] lock_,
    output logic [N_MASTERS-1:0] grnt_,
    output logic [OWNER_W-1:0]   owner,
    output logic                 preempt
);

    logic [OWNER_W-1:0]   r_owner;
    logic [N_MASTERS-1:0] w_req;
    logic [N_MASTERS-1:0] w_owner_oh;
    logic [N_MASTERS-1:0] w_others;
    logic [OWNER_W-1:0]   w_owner_idx;
    logic [OWNER_W-1:0]   w_start;
    logic [OWNER_W-1:0]   w_pick_idx;
    logic                 w_found;
    logic                 w_owner_req;
    logic                 w_preempt_take;
    logic                 w_move;

    assign w_req = ~req_;

    // An out-of-range owner is treated as master 0 for both decode and search.
    assign w_owner_idx = (int'(r_owner) < N_MASTERS) ? r_owner : '0;
    assign w_owner_req = w_req[w_owner_idx];
    assign w_start     = OWNER_W'(wrap_next(int'(w_owner_idx), N_MASTERS));

    always_comb begin
        w_owner_oh              = '0;
        w_owner_oh[w_owner_idx] = 1'b1;
    end

    // The owner is excluded, so one search serves both release and preemption.
    assign w_others = w_req & ~w_owner_oh;

    bus_arb_rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (OWNER_W)
    ) u_pick (
        .req   (w_others),
        .start (w_start),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    assign w_move = w_found && (!w_owner_req || w_preempt_take);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= '0;
        end else if (w_move) begin
            r_owner <= w_pick_idx;
        end
    end

`ifdef BUS_ARB_HOLD_LIMIT_EN
    localparam hold_cnt_t c_hold_max = hold_cnt_t'(MAX_HOLD - 1);

    hold_cnt_t r_hold_cnt;
    logic      r_preempt;

    assign w_preempt_take = w_owner_req && (r_hold_cnt == c_hold_max) &&
                            lock_[w_owner_idx] && w_found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
        end else if (w_move || !w_owner_req) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != c_hold_max) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= w_preempt_take;
        end
    end

    assign preempt = r_preempt;
`else
    localparam int c_unused_max_hold = MAX_HOLD;
    logic w_unused_lock;

    assign w_unused_lock  = ^lock_;
    assign w_preempt_take = 1'b0;
    assign preempt        = 1'b0;
`endif

    always_comb begin
        grnt_              = '1;
        grnt_[w_owner_idx] = 1'b0;
    end

    assign owner = r_owner;

endmodule

`default_nettype wire
